// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for the round-robin arbitrating mux: N input channels, one output.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned SW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  // Arbiter side: consumes the input channels, sources the output beat.
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Environment side: sources the input channels, sinks the output beat.
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a single registered output slot.
// Grant search starts at ptr; the winner's beat is captured into the output
// register whenever the slot is empty or being drained in the same cycle.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) (
  input logic          clk,
  input logic          rst_n,
  rr_arb_mux_if.master bus
);
  localparam int unsigned SW = $clog2(N);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    ptr_next;
  logic [SW:0]      cand_sum;
  logic [SW-1:0]    cand;
  logic             found;
  logic             load_en;
  logic [WIDTH-1:0] grant_data;
  logic [N-1:0]     ready_vec;

  logic             held_valid;
  logic [WIDTH-1:0] held_data;
  logic [SW-1:0]    held_sel;

  // Slot can accept a new beat when empty or when its beat leaves this cycle.
  assign load_en = !held_valid || bus.out_ready;

  // Circular search from ptr; iterating from the far end lets the nearest valid channel win.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr} + (SW+1)'(k);
      if (cand_sum >= (SW+1)'(N)) begin
        cand_sum = cand_sum - (SW+1)'(N);
      end
      cand = cand_sum[SW-1:0];
      if (bus.in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Pointer advances past the winner, wrapping explicitly so it never reaches N.
  always_comb begin
    ptr_next = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
  end

  // Select the granted channel's data slice.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == SW'(i)) begin
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready to the granted channel; held low while in reset.
  always_comb begin
    ready_vec = '0;
    if (rst_n && load_en && found) begin
      ready_vec[grant] = 1'b1;
    end
  end

  assign bus.in_ready = ready_vec;

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_data  <= '0;
      held_sel   <= '0;
      ptr        <= '0;
    end else if (load_en) begin
      if (found) begin
        held_valid <= 1'b1;
        held_data  <= grant_data;
        held_sel   <= grant;
        ptr        <= ptr_next;
      end else begin
        held_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = held_valid;
  assign bus.out_data  = held_data;
  assign bus.out_sel   = held_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a
// cycle-level reference model computed from the arbitration rules.
module tb_rr_arb_mux;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;

  rr_arb_mux_if #(.WIDTH(W), .N(N)) bus ();

  rr_arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;

  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First valid channel walking ptr, ptr+1, ... modulo N; -1 if none.
  function automatic int grant_of(input logic [N-1:0] v, input int p);
    for (int k = 0; k < int'(N); k++) begin
      if (v[(p + k) % int'(N)]) return (p + k) % int'(N);
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*W +: W] = $urandom();
    return d;
  endfunction

  // One clock cycle: drive, check ready pre-edge, advance model, check outputs post-edge.
  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic [N*W-1:0] d);
    int           g;
    logic         load;
    logic [N-1:0] exp_rdy;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.in_data   = d;
    #1;
    load    = !m_valid || rdy;
    g       = grant_of(v, m_ptr);
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    last_ready = bus.in_ready;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = d[g*W +: W];
        m_sel   = g;
        m_ptr   = (g + 1) % int'(N);
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_sel", 64'(bus.out_sel), 64'(m_sel));
    check("out_data", 64'(bus.out_data), 64'(m_data));
  endtask

  // Assert reset between edges with all channels requesting; outputs must clear at once.
  task automatic apply_reset();
    bus.in_valid  = '1;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sel", 64'(bus.out_sel), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
    #1;
    bus.in_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N*W-1:0] d1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
    last_ready = '0;

    apply_reset();

    // Single channel request.
    d = '0;
    d[2*W +: W] = 32'hDEADBEEF;
    cycle(4'b0100, 1'b1, d);
    check("single_ready", 64'(last_ready), 64'b0100);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_data", 64'(bus.out_data), 64'hDEADBEEF);
    check("single_sel", 64'(bus.out_sel), 64'd2);

    // Reset while a beat is held (data nonzero) must clear everything.
    apply_reset();

    // Full-load round robin.
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 1'b1, rand_data());
      check("rr_sel", 64'(bus.out_sel), 64'(i % 4));
      check("rr_valid", 64'(bus.out_valid), 64'd1);
    end

    // Backpressure on a beat from channel 1.
    apply_reset();
    d1 = rand_data();
    cycle(4'b0010, 1'b1, d1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, rand_data());
      check("bp_ready", 64'(last_ready), 64'd0);
      check("bp_sel", 64'(bus.out_sel), 64'd1);
      check("bp_data", 64'(bus.out_data), 64'(d1[1*W +: W]));
    end
    cycle(4'b1111, 1'b1, rand_data());
    check("bp_next_ready", 64'(last_ready), 64'b0100);
    check("bp_next_sel", 64'(bus.out_sel), 64'd2);

    // Wrap from ptr=3 and skip idle channels.
    apply_reset();
    cycle(4'b0100, 1'b1, rand_data());
    cycle(4'b1001, 1'b1, rand_data());
    check("wrap_ready3", 64'(last_ready), 64'b1000);
    check("wrap_sel3", 64'(bus.out_sel), 64'd3);
    cycle(4'b1001, 1'b1, rand_data());
    check("wrap_ready0", 64'(last_ready), 64'b0001);
    check("wrap_sel0", 64'(bus.out_sel), 64'd0);
    cycle(4'b1111, 1'b1, rand_data());
    check("wrap_ptr1", 64'(last_ready), 64'b0010);

    // Mid-operation reset restarts the search at channel 0.
    apply_reset();
    cycle(4'b0100, 1'b1, rand_data());
    check("mid_sel2", 64'(bus.out_sel), 64'd2);
    apply_reset();
    cycle(4'b1111, 1'b1, rand_data());
    check("mid_first_sel", 64'(bus.out_sel), 64'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rand_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel, legal range 1 or greater.
REQ-002 Parameter N, default 4: number of input channels, legal range 2 or greater.
REQ-003 Parameter SW, default $clog2(N): width of the channel index; derived, never overridden.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  N  per-channel valid; bit i belongs to channel i.
REQ-007 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel ready; at most one bit is high in any cycle.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  WIDTH  registered data of the held beat.
REQ-011 out_sel  output  SW  registered index of the channel that sourced the held beat.
REQ-012 out_ready  input  1  downstream accepts the held beat.

Function
REQ-013 Input transfer on channel i occurs when in_valid[i] and in_ready[i] are both high at a rising edge; output transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-014 load_en = !out_valid || out_ready; the block accepts a new beat only when load_en is high.
REQ-015 Round-robin pointer ptr (SW bits): the grant goes to the first channel with in_valid high, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
REQ-016 in_ready[g] = load_en && any(in_valid) for granted channel g; every other in_ready bit is 0.
REQ-017 in_ready may depend combinationally on in_valid, ptr, out_valid and out_ready; out_data, out_sel and out_valid have no combinational path from any input.
REQ-018 On an input transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N; latency is 1 cycle from input transfer to out_valid.
REQ-019 When load_en is high and no in_valid bit is set: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-020 When load_en is low (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr hold, and in_ready is all zero (backpressure).
REQ-021 Simultaneous output and input transfer in the same cycle: the new beat replaces the old one with no bubble, giving sustained throughput of 1 beat/cycle.
REQ-022 ptr wrap: when g = N-1, ptr becomes 0; for N not a power of two, ptr never takes values of N or greater.
REQ-023 Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...; no channel waits more than N-1 transfers.
REQ-024 in_valid changes while a channel is not granted are legal; no grant is reserved across cycles.
REQ-025 No data is dropped or duplicated: each input transfer produces exactly one output transfer, in grant order.

Reset
REQ-026 rst_n low asynchronously forces out_valid=0, out_data=0, out_sel=0 and ptr=0, independent of clk.
REQ-027 While rst_n is low, in_ready is all zero.
REQ-028 Reset asserted mid-operation discards the held beat; the first grant after release searches from channel 0.
REQ-029 Deassertion of rst_n is synchronous to clk externally; the first active edge after release behaves as a normal cycle.

Verification
REQ-030 Reset check, N=4, WIDTH=32: assert rst_n=0 between edges -> out_valid=0, out_data=0, out_sel=0 and in_ready=0000 immediately.
REQ-031 Single channel: in_valid=0100, in_data[2]=0xDEADBEEF, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2.
REQ-032 Round robin: in_valid=1111 held, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1 with out_valid continuously 1.
REQ-033 Backpressure: hold a beat from channel 1, out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000; out_data and out_sel stay stable; after out_ready=1 the next grant is channel 2.
REQ-034 Wrap and skip: ptr=3, in_valid=1001 -> grant 3; then the next grant is channel 0 and ptr becomes 1.
REQ-035 Mid-operation reset: pulse rst_n low while out_valid=1, out_sel=2 -> outputs clear; after release with in_valid=1111, the first out_sel is 0.
